// File: rtl/mem_bist.sv
// mem_bist: March C- built-in self-test controller for a 16x16 memory.
// Runs M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0;
// M5 up r0, where "0" is BG and "1" is ~BG.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             run request, honoured only in IDLE
//   busy, done        run in progress / one-cycle end-of-run pulse
//   fail, err_cnt     sticky mismatch flag and mismatch count for the run
//   fail_addr/elem/data  details captured at the first mismatch
//   mem_wr_en, mem_addrw, mem_wdata   memory write port
//   mem_rd_en, mem_addrr, mem_rdata   memory read port (data one cycle later)
`timescale 1ns/1ps
module mem_bist #(
    parameter logic [15:0] BG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [6:0]  err_cnt,
    output logic [3:0]  fail_addr,
    output logic [2:0]  fail_elem,
    output logic [15:0] fail_data,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [3:0]  mem_addrw,
    output logic [3:0]  mem_addrr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned AW = 4;
    localparam int unsigned EW = 3;
    localparam int unsigned CW = 7;
    localparam logic [AW-1:0] ADDR_LAST = AW'(15);
    localparam logic [CW-1:0] ERR_MAX   = CW'(80);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [EW-1:0]   elem_q;
    logic [AW-1:0]   addr_q;
    logic            phase_q;   // 0: cycle A (read/write), 1: cycle B (compare)

    logic [EW-1:0]   elem_d;
    logic [AW-1:0]   addr_d;
    logic            phase_d;
    logic            last_step;
    logic            wr_en_d;
    logic            rd_en_d;
    logic [15:0]     wdata_d;
    logic [15:0]     exp_word;
    logic            mismatch;

    // M3 and M4 walk the address space downwards
    function automatic logic elem_down(input logic [EW-1:0] e);
        return (e == EW'(3)) || (e == EW'(4));
    endfunction

    // Sequencer: next march position after the current one
    always_comb begin
        elem_d    = elem_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        last_step = 1'b0;
        if (elem_q == '0) begin
            if (addr_q == ADDR_LAST) begin
                elem_d  = EW'(1);
                addr_d  = '0;
                phase_d = 1'b0;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end else if (!phase_q) begin
            phase_d = 1'b1;
        end else begin
            phase_d = 1'b0;
            if (addr_q == (elem_down(elem_q) ? AW'(0) : ADDR_LAST)) begin
                if (elem_q == EW'(5)) begin
                    last_step = 1'b1;
                end else begin
                    elem_d = elem_q + EW'(1);
                    addr_d = elem_down(elem_q + EW'(1)) ? ADDR_LAST : AW'(0);
                end
            end else begin
                addr_d = elem_down(elem_q) ? addr_q - AW'(1) : addr_q + AW'(1);
            end
        end
    end

    // Memory controls for the next position; M5 cycle B is compare-only
    always_comb begin
        wr_en_d = (elem_d == '0) || (phase_d && (elem_d != EW'(5)));
        rd_en_d = (elem_d != '0) && !phase_d;
        wdata_d = ((elem_d == EW'(1)) || (elem_d == EW'(3))) ? ~BG : BG;
    end

    // Read data arrives in cycle B of the current position
    always_comb begin
        exp_word = ((elem_q == EW'(2)) || (elem_q == EW'(4))) ? ~BG : BG;
        mismatch = phase_q && (elem_q != '0) && (mem_rdata != exp_word);
    end

    // Controller state, status and memory-port registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            elem_q    <= '0;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addrw <= '0;
            mem_addrr <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        busy      <= 1'b1;
                        fail      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        fail_data <= '0;
                        elem_q    <= '0;
                        addr_q    <= '0;
                        phase_q   <= 1'b0;
                        mem_wr_en <= 1'b1;
                        mem_rd_en <= 1'b0;
                        mem_addrw <= '0;
                        mem_wdata <= BG;
                    end
                end
                S_RUN: begin
                    if (mismatch) begin
                        fail <= 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + CW'(1);
                        end
                        // fail is still clear only before the first mismatch
                        if (!fail) begin
                            fail_addr <= addr_q;
                            fail_elem <= elem_q;
                            fail_data <= mem_rdata;
                        end
                    end
                    if (last_step) begin
                        state_q   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_wr_en <= 1'b0;
                        mem_rd_en <= 1'b0;
                    end else begin
                        elem_q    <= elem_d;
                        addr_q    <= addr_d;
                        phase_q   <= phase_d;
                        mem_wr_en <= wr_en_d;
                        mem_rd_en <= rd_en_d;
                        mem_addrw <= addr_d;
                        mem_addrr <= addr_d;
                        mem_wdata <= wdata_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: self-checking bench for mem_bist (BG = 0) with a 16x16
// memory model that supports per-address stuck-at-0/stuck-at-1 masks.
`timescale 1ns/1ps
module tb_mem_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        fail;
    logic [6:0]  err_cnt;
    logic [3:0]  fail_addr;
    logic [2:0]  fail_elem;
    logic [15:0] fail_data;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [3:0]  mem_addrw;
    logic [3:0]  mem_addrr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    mem_bist #(.BG(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addrw (mem_addrw),
        .mem_addrr (mem_addrr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with stuck-at faults
    logic [15:0] mem   [16];
    logic [15:0] sa0_m [16];
    logic [15:0] sa1_m [16];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addrw] <= (mem_wdata & ~sa0_m[mem_addrw]) | sa1_m[mem_addrw];
        if (mem_rd_en) mem_rdata <= (mem[mem_addrr] & ~sa0_m[mem_addrr]) | sa1_m[mem_addrr];
    end

    // Protocol monitor
    int          ovl_cnt;
    int          idle_en_cnt;
    int          done_cnt;
    logic [3:0]  rdq[$];
    logic [3:0]  wrq[$];

    initial begin
        ovl_cnt     = 0;
        idle_en_cnt = 0;
        done_cnt    = 0;
    end

    always @(posedge clk) begin
        if (mem_wr_en && mem_rd_en) ovl_cnt++;
        if ((mem_wr_en || mem_rd_en) && !busy) idle_en_cnt++;
        if (mem_rd_en) rdq.push_back(mem_addrr);
        if (mem_wr_en) wrq.push_back(mem_addrw);
        if (done) done_cnt++;
    end

    int checks;
    int errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  sa0_a;
        logic [15:0] sa0_v;
        logic [3:0]  sa1_a;
        logic [15:0] sa1_v;
        logic        e_fail;
        logic [6:0]  e_cnt;
        logic [3:0]  e_addr;
        logic [2:0]  e_elem;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[7];

    task automatic set_faults(input logic [3:0] a0, input logic [15:0] m0,
                              input logic [3:0] a1, input logic [15:0] m1);
        for (int i = 0; i < 16; i++) begin
            sa0_m[i] = 16'h0000;
            sa1_m[i] = 16'h0000;
        end
        sa0_m[a0] = m0;
        sa1_m[a1] = m1;
    endtask

    function automatic logic [3:0] exp_rd_addr(input int i);
        int e = i / 16;
        int j = i % 16;
        return (e == 2 || e == 3) ? 4'(15 - j) : 4'(j);
    endfunction

    function automatic logic [3:0] exp_wr_addr(input int i);
        int e = i / 16;
        int j = i % 16;
        return (e == 3 || e == 4) ? 4'(15 - j) : 4'(j);
    endfunction

    // One full run from a start pulse; checks timing, status and address order
    task automatic run_vec(input vec_t v, input int id);
        int n;
        int bad;
        int ovl0;
        int idle0;
        set_faults(v.sa0_a, v.sa0_v, v.sa1_a, v.sa1_v);
        rdq.delete();
        wrq.delete();
        ovl0  = ovl_cnt;
        idle0 = idle_en_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_busy_first", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d_fail_clear", id), 32'(fail), 32'd0);
        chk($sformatf("v%0d_cnt_clear", id), 32'(err_cnt), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_run_cycles", id), 32'(n), 32'd176);
        chk($sformatf("v%0d_done", id), 32'(done), 32'd1);
        chk($sformatf("v%0d_fail", id), 32'(fail), 32'(v.e_fail));
        chk($sformatf("v%0d_err_cnt", id), 32'(err_cnt), 32'(v.e_cnt));
        chk($sformatf("v%0d_fail_addr", id), 32'(fail_addr), 32'(v.e_addr));
        chk($sformatf("v%0d_fail_elem", id), 32'(fail_elem), 32'(v.e_elem));
        chk($sformatf("v%0d_fail_data", id), 32'(fail_data), 32'(v.e_data));
        @(negedge clk);
        chk($sformatf("v%0d_done_width", id), 32'(done), 32'd0);
        chk($sformatf("v%0d_hold_cnt", id), 32'(err_cnt), 32'(v.e_cnt));
        bad = 0;
        if (rdq.size() != 80) bad = 1000 + rdq.size();
        else for (int i = 0; i < 80; i++) if (rdq[i] != exp_rd_addr(i)) bad++;
        chk($sformatf("v%0d_rd_order", id), 32'(bad), 32'd0);
        bad = 0;
        if (wrq.size() != 80) bad = 1000 + wrq.size();
        else for (int i = 0; i < 80; i++) if (wrq[i] != exp_wr_addr(i)) bad++;
        chk($sformatf("v%0d_wr_order", id), 32'(bad), 32'd0);
        chk($sformatf("v%0d_rd_wr_overlap", id), 32'(ovl_cnt - ovl0), 32'd0);
        chk($sformatf("v%0d_en_outside_run", id), 32'(idle_en_cnt - idle0), 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int cyc;
        int done0;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        set_faults(4'd0, 16'h0000, 4'd0, 16'h0000);

        //           sa0_a  sa0_v     sa1_a  sa1_v     fail  cnt    addr   elem   data
        vecs[0] = '{4'd0,  16'h0000, 4'd0,  16'h0000, 1'b0, 7'd0, 4'd0,  3'd0, 16'h0000};
        vecs[1] = '{4'd5,  16'h0008, 4'd0,  16'h0000, 1'b1, 7'd2, 4'd5,  3'd2, 16'hFFF7};
        vecs[2] = '{4'd0,  16'h0000, 4'd0,  16'hFFFF, 1'b1, 7'd3, 4'd0,  3'd1, 16'hFFFF};
        vecs[3] = '{4'd0,  16'h0000, 4'd15, 16'h0001, 1'b1, 7'd3, 4'd15, 3'd1, 16'h0001};
        vecs[4] = '{4'd10, 16'h8000, 4'd0,  16'h0000, 1'b1, 7'd2, 4'd10, 3'd2, 16'h7FFF};
        vecs[5] = '{4'd12, 16'h0080, 4'd3,  16'h0001, 1'b1, 7'd5, 4'd3,  3'd1, 16'h0001};
        vecs[6] = '{4'd7,  16'hFFFF, 4'd0,  16'h0000, 1'b1, 7'd2, 4'd7,  3'd2, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_fail_info", {13'd0, fail_addr, fail_elem, fail_data[11:0]}, 32'd0);
        chk("rst_mem_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        chk("rst_mem_bus", 32'({mem_addrw, mem_addrr, mem_wdata}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in RUN cycle 50 aborts the run with no done pulse
        set_faults(4'd0, 16'h0000, 4'd0, 16'hFFFF);
        done0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_fail", 32'(fail), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        chk("abort_status", 32'({fail, err_cnt, done}), 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        run_vec(vecs[0], 10);

        // start held high: back-to-back runs, fail cleared at each accepted start
        set_faults(4'd5, 16'h0008, 4'd0, 16'h0000);
        @(negedge clk);
        start = 1'b1;
        t1  = -1;
        t2  = -1;
        cyc = 0;
        while (t2 < 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    chk("b2b_fail_run1", 32'(fail), 32'd1);
                end else begin
                    t2 = cyc;
                    start = 1'b0;
                    chk("b2b_fail_run2", 32'(fail), 32'd1);
                    chk("b2b_cnt_run2", 32'(err_cnt), 32'd2);
                end
            end
            if (t1 >= 0 && cyc == t1 + 1) chk("b2b_idle_hold", 32'({busy, fail}), 32'b01);
            if (t1 >= 0 && cyc == t1 + 2) chk("b2b_restart_clear", 32'({busy, fail}), 32'b10);
        end
        chk("b2b_done_spacing", 32'(t2 - t1), 32'd178);
        repeat (3) @(negedge clk);
        chk("b2b_stops", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
